noise_voice_scheduler: RTL

Shares the single LFSR noise source among NUM_VOICES drum voices (snare, hi-hat, clap, …). It accepts per-voice trigger pulses and arbitrates ownership of the noise source by fixed priority. It reseeds the generator at each hit start and applies a per-voice exponential-rate linear decay envelope. It sits between the sequencer's trigger outputs and the mixer, driving the noise generator's reset and consuming its 10-bit output.

---
 rtl/noise_voice_scheduler_pkg.sv | 25 ++
 rtl/noise_voice_scheduler_if.sv | 24 ++
 rtl/noise_voice_scheduler_envelope.sv | 58 +++++
 rtl/noise_voice_scheduler.sv | 122 ++++++++++++
 4 files changed

// File: rtl/noise_voice_scheduler_pkg.sv
// rtl/noise_voice_scheduler_pkg.sv - shared types, default widths and helpers for the noise voice scheduler
package noise_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEED = 2'd1,
    ST_PLAY = 2'd2
  } state_e;

  localparam int DEF_ENV_WIDTH  = 8;
  localparam int DEF_RATE_WIDTH = 4;
  localparam int ENV_MAX        = (2 ** DEF_ENV_WIDTH) - 1;
  // Wide enough to count 0 .. 2^rate-1 for the largest rate code.
  localparam int PRESC_WIDTH    = (2 ** DEF_RATE_WIDTH) - 1;

  function automatic int lowest_set(input logic [31:0] v);
    int result;
    result = 0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) result = i;
    end
    return result;
  endfunction

endpackage

// File: rtl/noise_voice_scheduler_if.sv
// rtl/noise_voice_scheduler_if.sv - trigger, noise and audio-side signal bundle of the scheduler
interface noise_voice_scheduler_if #(
  parameter int NUM_VOICES  = 4,
  parameter int RATE_WIDTH  = 4,
  parameter int OWNER_WIDTH = 2
);
  logic [NUM_VOICES-1:0]            trig;
  logic [NUM_VOICES*RATE_WIDTH-1:0] decay_rate;
  logic [9:0]                       noise_in;
  logic                             noise_reset;
  logic [9:0]                       voice_out;
  logic [OWNER_WIDTH-1:0]           owner;
  logic                             active;

  modport master (
    output trig, decay_rate, noise_in,
    input  noise_reset, voice_out, owner, active
  );

  modport slave (
    input  trig, decay_rate, noise_in,
    output noise_reset, voice_out, owner, active
  );
endinterface

// File: rtl/noise_voice_scheduler_envelope.sv
// rtl/noise_voice_scheduler_envelope.sv - rate prescaler and linear envelope down-counter
module noise_envelope #(
  parameter int ENV_WIDTH   = 8,
  parameter int RATE_WIDTH  = 4,
  parameter int PRESC_WIDTH = (2 ** RATE_WIDTH) - 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  step_en,
  input  logic [RATE_WIDTH-1:0] rate,
  output logic [ENV_WIDTH-1:0]  env,
  output logic                  done
);
  logic [RATE_WIDTH-1:0]  rate_q, rate_d;
  logic [PRESC_WIDTH-1:0] presc_q, presc_d, presc_term;
  logic [ENV_WIDTH-1:0]   env_q, env_d;
  logic                   terminal;

  always_comb begin
    presc_term = '0;
    for (int i = 0; i < PRESC_WIDTH; i++) begin
      presc_term[i] = (i < int'(rate_q));
    end
    terminal = (presc_q == presc_term);
    done     = step_en && terminal && (env_q == ENV_WIDTH'(1));

    rate_d  = rate_q;
    presc_d = presc_q;
    env_d   = env_q;
    if (load) begin
      rate_d  = rate;
      presc_d = '0;
      env_d   = '1;
    end else if (step_en) begin
      if (terminal) begin
        presc_d = '0;
        if (env_q != '0) env_d = env_q - ENV_WIDTH'(1);
      end else begin
        presc_d = presc_q + PRESC_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rate_q  <= '0;
      presc_q <= '0;
      env_q   <= '0;
    end else begin
      rate_q  <= rate_d;
      presc_q <= presc_d;
      env_q   <= env_d;
    end
  end

  assign env = env_q;
endmodule

// File: rtl/noise_voice_scheduler.sv
// rtl/noise_voice_scheduler.sv - fixed-priority owner of the shared noise source; NOISE_SCHED_QUEUE_EN adds pending queue
module noise_voice_scheduler
  import noise_sched_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int ENV_WIDTH  = DEF_ENV_WIDTH,
  parameter int RATE_WIDTH = DEF_RATE_WIDTH
) (
  input  logic              audio_tick,
  input  logic              reset,
  noise_voice_scheduler_if.slave bus
);
  localparam int OW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] SEED = ST_SEED;
  localparam logic [1:0] PLAY = ST_PLAY;

  logic [1:0]              state_q, state_d;
  logic [OW-1:0]           owner_q, owner_d;
  logic [OW-1:0]           win_idx, req_idx, pend_idx;
  logic                    noise_reset_q, noise_reset_d;
  logic                    active_q, active_d;
  logic [9:0]              voice_out_q, voice_out_d;
  logic [NUM_VOICES-1:0]   pend_set, req;
  logic [RATE_WIDTH-1:0]   owner_rate;
  logic [ENV_WIDTH-1:0]    env;
  logic                    env_done;
  logic [9+ENV_WIDTH:0]    product;

`ifdef NOISE_SCHED_QUEUE_EN
  logic [NUM_VOICES-1:0] pending_q, pending_d;

  // Every trig not starting a hit this tick is parked; the starter's bit is cleared.
  assign pend_set = pending_q | bus.trig;

  always_comb begin
    pending_d = pend_set;
    if (state_d == SEED) pending_d[owner_d] = 1'b0;
  end

  always_ff @(posedge audio_tick) begin
    if (reset) pending_q <= '0;
    else       pending_q <= pending_d;
  end
`else
  assign pend_set = '0;
`endif

  assign owner_rate = bus.decay_rate[int'(owner_q)*RATE_WIDTH +: RATE_WIDTH];

  noise_envelope #(
    .ENV_WIDTH  (ENV_WIDTH),
    .RATE_WIDTH (RATE_WIDTH)
  ) u_env (
    .clk     (audio_tick),
    .reset   (reset),
    .load    (state_q == SEED),
    .step_en (state_q == PLAY),
    .rate    (owner_rate),
    .env     (env),
    .done    (env_done)
  );

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    req      = bus.trig | pend_set;
    win_idx  = OW'(lowest_set(32'(bus.trig)));
    req_idx  = OW'(lowest_set(32'(req)));
    pend_idx = OW'(lowest_set(32'(pend_set)));
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = SEED;
          owner_d = req_idx;
        end
      end
      SEED, PLAY: begin
        if ((|bus.trig) && (win_idx <= owner_q)) begin
          state_d = SEED;
          owner_d = win_idx;
        end else if (state_q == SEED) begin
          state_d = PLAY;
        end else if (env_done) begin
          if (|pend_set) begin
            state_d = SEED;
            owner_d = pend_idx;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    noise_reset_d = (state_d == SEED);
    active_d      = (state_d == PLAY);
    product       = {{ENV_WIDTH{1'b0}}, bus.noise_in} * {10'b0, env};
    voice_out_d   = (state_q == PLAY) ? 10'(product >> ENV_WIDTH) : 10'd0;
  end

  always_ff @(posedge audio_tick) begin
    if (reset) begin
      state_q       <= IDLE;
      owner_q       <= '0;
      noise_reset_q <= 1'b0;
      active_q      <= 1'b0;
      voice_out_q   <= '0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      noise_reset_q <= noise_reset_d;
      active_q      <= active_d;
      voice_out_q   <= voice_out_d;
    end
  end

  assign bus.noise_reset = noise_reset_q;
  assign bus.active      = active_q;
  assign bus.owner       = owner_q;
  assign bus.voice_out   = voice_out_q;
endmodule
